// File: rtl/qtable_best_hop.sv
// Walks the neighbor Q-table in node memory and reports the eligible neighbor with the
// highest Q-value (energy breaks ties, then the lower index is kept).
module qtable_best_hop #(
  parameter logic [10:0] NCOUNT_ADDR   = 11'd64,
  parameter logic [10:0] TABLE_BASE    = 11'd72,
  parameter int unsigned ENTRY_STRIDE  = 8,
  parameter int unsigned MAX_NEIGHBORS = 32
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] fclusterID,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] bestID,
  output logic [15:0] bestQ,
  output logic [15:0] bestEnergy,
  output logic        found,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_COUNT = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] FINISH   = 3'd4;

  // Jump from an entry's cluster word to the next entry's nodeID word.
  localparam logic [10:0] STRIDE_JUMP = 11'(ENTRY_STRIDE - 6);
  localparam logic [15:0] MAX_N       = 16'(MAX_NEIGHBORS);

  logic [2:0]  state_q;
  logic [10:0] addr_q;
  logic [17:0] word_q, last_word_q;
  logic        rd_wait_q;
  logic        iss0_q, iss1_q;  // table read issued / sampled by the RAM
  logic [1:0]  fld_q;
  logic [15:0] stg_id_q, stg_e_q, stg_q_q;
  logic        cmp_vld_q;
  logic [15:0] cmp_id_q, cmp_e_q, cmp_q_q, cmp_cl_q;
  logic        best_vld_q;
  logic [15:0] best_id_q, best_e_q, best_q_q;
  logic [15:0] out_id_q, out_e_q, out_q_q;
  logic        found_q, busy_q, done_q;

  logic [15:0] n_clamped;
  logic        cmp_elig, cmp_better, take;
  logic [15:0] fin_id, fin_e, fin_q;
  logic        fin_vld;

  always_comb begin
    n_clamped  = (data_in > MAX_N) ? MAX_N : data_in;
    cmp_elig   = cmp_vld_q && (cmp_e_q != 16'd0) &&
                 ((fclusterID == 16'hFFFF) || (cmp_cl_q == fclusterID));
    cmp_better = !best_vld_q || (cmp_q_q > best_q_q) ||
                 ((cmp_q_q == best_q_q) && (cmp_e_q > best_e_q));
    take       = cmp_elig && cmp_better;
    // The last entry is still in the compare stage on the finishing edge.
    fin_id     = take ? cmp_id_q : best_id_q;
    fin_e      = take ? cmp_e_q  : best_e_q;
    fin_q      = take ? cmp_q_q  : best_q_q;
    fin_vld    = take || best_vld_q;
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      last_word_q <= '0;
      rd_wait_q   <= 1'b0;
      iss0_q      <= 1'b0;
      iss1_q      <= 1'b0;
      fld_q       <= '0;
      stg_id_q    <= '0;
      stg_e_q     <= '0;
      stg_q_q     <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_id_q    <= '0;
      cmp_e_q     <= '0;
      cmp_q_q     <= '0;
      cmp_cl_q    <= '0;
      best_vld_q  <= 1'b0;
      best_id_q   <= '0;
      best_e_q    <= '0;
      best_q_q    <= '0;
      out_id_q    <= '0;
      out_e_q     <= '0;
      out_q_q     <= '0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if ((state_q != IDLE) && !en) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_wait_q <= 1'b0;
      iss0_q    <= 1'b0;
      iss1_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      iss1_q    <= iss0_q;
      cmp_vld_q <= 1'b0;

      if (iss1_q) begin
        fld_q <= fld_q + 2'd1;
        case (fld_q)
          2'd0: stg_id_q <= data_in;
          2'd1: stg_e_q  <= data_in;
          2'd2: stg_q_q  <= data_in;
          default: begin
            cmp_vld_q <= 1'b1;
            cmp_id_q  <= stg_id_q;
            cmp_e_q   <= stg_e_q;
            cmp_q_q   <= stg_q_q;
            cmp_cl_q  <= data_in;
          end
        endcase
      end

      if (take) begin
        best_vld_q <= 1'b1;
        best_id_q  <= cmp_id_q;
        best_e_q   <= cmp_e_q;
        best_q_q   <= cmp_q_q;
      end

      case (state_q)
        IDLE: begin
          if (start && en) begin
            state_q    <= RD_COUNT;
            addr_q     <= NCOUNT_ADDR;
            busy_q     <= 1'b1;
            rd_wait_q  <= 1'b1;
            iss0_q     <= 1'b0;
            iss1_q     <= 1'b0;
            fld_q      <= '0;
            best_vld_q <= 1'b0;
            best_id_q  <= '0;
            best_e_q   <= '0;
            best_q_q   <= '0;
          end
        end
        RD_COUNT: begin
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else if (n_clamped == 16'd0) begin
            state_q <= FINISH;
          end else begin
            state_q     <= STREAM;
            addr_q      <= TABLE_BASE;
            word_q      <= '0;
            last_word_q <= {n_clamped, 2'b00} - 18'd1;
            iss0_q      <= 1'b1;
          end
        end
        STREAM: begin
          if (word_q == last_word_q) begin
            state_q <= DRAIN;
            iss0_q  <= 1'b0;
          end else begin
            addr_q <= (word_q[1:0] == 2'd3) ? addr_q + STRIDE_JUMP : addr_q + 11'd2;
            word_q <= word_q + 18'd1;
            iss0_q <= 1'b1;
          end
        end
        DRAIN: begin
          // Last cluster word lands this edge once no further reads are in flight.
          if (iss1_q && !iss0_q) state_q <= FINISH;
        end
        FINISH: begin
          out_id_q <= fin_id;
          out_e_q  <= fin_e;
          out_q_q  <= fin_q;
          found_q  <= fin_vld;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = addr_q;
  assign bestID     = out_id_q;
  assign bestQ      = out_q_q;
  assign bestEnergy = out_e_q;
  assign found      = found_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_qtable_best_hop.sv
// Randomized and directed scans of a modelled Q-table memory, compared against a plain
// loop-over-entries reference of the best-hop selection rules.
module tb_qtable_best_hop;

  logic        clock = 1'b0;
  logic        nrst, en, start;
  logic [15:0] fclusterID;
  logic [15:0] data_in;
  logic [10:0] address;
  logic [15:0] bestID, bestQ, bestEnergy;
  logic        found, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:1023];

  qtable_best_hop dut (
    .clock      (clock),
    .nrst       (nrst),
    .en         (en),
    .start      (start),
    .fclusterID (fclusterID),
    .data_in    (data_in),
    .address    (address),
    .bestID     (bestID),
    .bestQ      (bestQ),
    .bestEnergy (bestEnergy),
    .found      (found),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM, one cycle of latency.
  always @(posedge clock) data_in <= mem[address[10:1]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
  endtask

  task automatic set_entry(input int idx, input logic [15:0] id, input logic [15:0] e,
                           input logic [15:0] q, input logic [15:0] cl);
    int w;
    w = (72 + 8 * idx) / 2;
    mem[w]     = id;
    mem[w + 1] = e;
    mem[w + 2] = q;
    mem[w + 3] = cl;
  endtask

  task automatic model(input logic [15:0] filt, output int n, output logic [15:0] m_id,
                       output logic [15:0] m_e, output logic [15:0] m_q, output logic m_found);
    logic [15:0] id, e, q, cl;
    n = (mem[32] > 16'd32) ? 32 : int'(mem[32]);
    m_found = 1'b0;
    m_id = 0;
    m_e = 0;
    m_q = 0;
    for (int i = 0; i < n; i++) begin
      id = mem[36 + 4 * i];
      e  = mem[37 + 4 * i];
      q  = mem[38 + 4 * i];
      cl = mem[39 + 4 * i];
      if (e != 0 && (filt == 16'hFFFF || cl == filt)) begin
        if (!m_found || q > m_q || (q == m_q && e > m_e)) begin
          m_found = 1'b1;
          m_id = id;
          m_e = e;
          m_q = q;
        end
      end
    end
  endtask

  // abort_at < 0: normal scan; otherwise en is low at edge S+abort_at.
  task automatic run_scan(input string tag, input logic [15:0] filt, input int abort_at,
                          input bit poke_start);
    int n, exp_lat, lat, addr_err, hold_err, ea;
    logic [15:0] m_id, m_e, m_q, p_id, p_e, p_q;
    logic m_found, p_found;
    model(filt, n, m_id, m_e, m_q, m_found);
    exp_lat = (n == 0) ? 3 : 4 + 4 * n;
    p_id = bestID;
    p_e = bestEnergy;
    p_q = bestQ;
    p_found = found;
    addr_err = 0;
    hold_err = 0;
    lat = -1;
    @(negedge clock);
    fclusterID = filt;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    for (int t = 0; t < 300; t++) begin
      if (t > 0) begin
        @(posedge clock);
        #1;
      end
      if (abort_at < 0 || t < abort_at) begin
        if (t < 2 || n == 0) ea = 64;
        else if (t - 2 < 4 * n) ea = 72 + 2 * (t - 2);
        else ea = 72 + 2 * (4 * n - 1);
        if (address !== 11'(ea)) addr_err++;
      end
      if (done) begin
        lat = t;
        break;
      end
      if (bestID !== p_id || bestQ !== p_q || bestEnergy !== p_e || found !== p_found)
        hold_err++;
      if (abort_at >= 0 && t == abort_at) begin
        check({tag, "_abort_busy"}, busy, 1'b0);
        break;
      end
      if (abort_at >= 0 && t == abort_at - 1) en = 1'b0;
      if (poke_start && t == 3) start = 1'b1;
      if (poke_start && t == 4) start = 1'b0;
    end
    check({tag, "_addr_trace"}, addr_err, 0);
    if (abort_at >= 0) begin
      check({tag, "_abort_nodone"}, lat, -1);
      for (int t = 0; t < 20; t++) begin
        @(posedge clock);
        #1;
        if (done || busy) hold_err++;
        if (bestID !== p_id || bestQ !== p_q || bestEnergy !== p_e || found !== p_found)
          hold_err++;
      end
      en = 1'b1;
      check({tag, "_abort_hold"}, hold_err, 0);
    end else begin
      check({tag, "_hold"}, hold_err, 0);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, {found, bestID, bestQ}, {m_found, m_id, m_q});
      check({tag, "_energy"}, bestEnergy, m_e);
      check({tag, "_busy_end"}, busy, 1'b0);
      @(posedge clock);
      #1;
      check({tag, "_done_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] filt;
    int r, cnt;
    nrst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    fclusterID = 16'hFFFF;
    clear_table();
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {address, bestID, bestQ, bestEnergy, found, busy, done}, '0);
    nrst = 1'b1;

    // Count zero.
    run_scan("zero", 16'hFFFF, -1, 1'b0);
    check("zero_found", found, 1'b0);

    // Three-entry table.
    mem[32] = 16'd3;
    set_entry(0, 5, 100, 40, 1);
    set_entry(1, 9, 80, 70, 2);
    set_entry(2, 12, 90, 55, 1);
    run_scan("tp_any", 16'hFFFF, -1, 1'b0);
    check("tp_any_const", {bestID, bestQ, bestEnergy}, {16'd9, 16'd70, 16'd80});
    run_scan("tp_cl1", 16'd1, -1, 1'b1);
    check("tp_cl1_const", {bestID, bestQ}, {16'd12, 16'd55});

    // Ties, then a zero-energy entry with a higher Q.
    set_entry(0, 3, 50, 60, 1);
    set_entry(1, 4, 70, 60, 1);
    set_entry(2, 6, 70, 60, 1);
    run_scan("tie", 16'hFFFF, -1, 1'b0);
    check("tie_const", bestID, 16'd4);
    mem[32] = 16'd4;
    set_entry(3, 7, 0, 99, 1);
    run_scan("tie_zero_e", 16'd1, -1, 1'b0);
    check("tie_zero_e_const", bestID, 16'd4);

    // Oversized count with a tempting entry beyond the clamp.
    clear_table();
    mem[32] = 16'd200;
    for (int i = 0; i < 32; i++) set_entry(i, 16'(100 + i), 16'(1 + i % 5), 16'(i % 7), 0);
    set_entry(32, 16'hBEEF, 16'd1, 16'hFFFF, 0);
    run_scan("clamp", 16'hFFFF, -1, 1'b0);
    check("clamp_not_beyond", bestQ, 16'd6);

    // Abort mid-scan; prior result must survive.
    run_scan("abort", 16'hFFFF, 10, 1'b0);

    // Randomized tables.
    for (int it = 0; it < 25; it++) begin
      clear_table();
      r = $urandom_range(0, 9);
      cnt = (r == 0) ? 0 : (r == 1) ? $urandom_range(33, 300) : $urandom_range(1, 12);
      mem[32] = 16'(cnt);
      for (int i = 0; i < 34; i++)
        set_entry(i, 16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4)),
                  16'($urandom_range(0, 5)), 16'($urandom_range(0, 3)));
      filt = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      run_scan("rand", filt, -1, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a scan after a found result.
    clear_table();
    mem[32] = 16'd2;
    set_entry(0, 21, 5, 9, 0);
    set_entry(1, 22, 6, 3, 0);
    run_scan("pre_rst", 16'hFFFF, -1, 1'b0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    nrst = 1'b0;
    @(posedge clock);
    #1;
    check("rst_mid", {address, bestID, bestQ, bestEnergy, found, busy, done}, '0);
    nrst = 1'b1;
    run_scan("post_rst", 16'hFFFF, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
